bram_port_arbiter: RTL

Sequences port A of the 64 KB dual-port block RAM (`ram_64kb`) and shares it between two requesters: the CPU core and a DMA/loader engine, which fills RAM from the host link. Each requester issues single-byte read/write transactions over a req/ack handshake. The arbiter drives the BRAM strobe clock, write enable, address and data in a fixed three-phase sequence, and returns read data. Port B (the video/scan side) is untouched.

---
 rtl/bram_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares port A of the 64 KB block RAM between the CPU and the DMA/loader.
// Each access runs IDLE -> SETUP -> STROBE -> CAPTURE. The BRAM strobe,
// write enable, address and data are all driven from registers. The DMA is
// forced to win after STARVE_LIMIT consecutive CPU grants made while the
// DMA was waiting.
module bram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_ack,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_ram_clka,
    output logic              o_ram_wea,
    output logic [ADDR_W-1:0] o_ram_addra,
    output logic [DATA_W-1:0] o_ram_dia,
    input  logic [DATA_W-1:0] i_ram_doa,
    output logic              o_busy,
    output logic              o_owner
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t              state_r;
    logic [3:0]          starve_r;
    logic                we_r;
    logic                owner_r;
    logic                busy_r;
    logic                clka_r;
    logic                wea_r;
    logic [ADDR_W-1:0]   addra_r;
    logic [DATA_W-1:0]   dia_r;
    logic                cpu_ack_r;
    logic                dma_ack_r;
    logic [DATA_W-1:0]   cpu_rdata_r;
    logic [DATA_W-1:0]   dma_rdata_r;

    logic                any_req_s;
    logic                grant_dma_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [3:0]          starve_nxt_s;

    // Pick the winner: CPU by default, DMA when alone or when it has been starved.
    always_comb begin
        any_req_s   = i_cpu_req | i_dma_req;
        grant_dma_s = 1'b0;
        if (i_dma_req && (!i_cpu_req || (starve_r == STARVE_MAX))) begin
            grant_dma_s = 1'b1;
        end else begin
            grant_dma_s = 1'b0;
        end
    end

    // Route the winner's transaction fields toward the latch registers.
    always_comb begin
        sel_we_s    = i_cpu_we;
        sel_addr_s  = i_cpu_addr;
        sel_wdata_s = i_cpu_wdata;
        if (grant_dma_s) begin
            sel_we_s    = i_dma_we;
            sel_addr_s  = i_dma_addr;
            sel_wdata_s = i_dma_wdata;
        end else begin
            sel_we_s    = i_cpu_we;
            sel_addr_s  = i_cpu_addr;
            sel_wdata_s = i_cpu_wdata;
        end
    end

    // Next starve count as seen from IDLE: count contested CPU wins, clear otherwise.
    always_comb begin
        starve_nxt_s = starve_r;
        if (!i_dma_req) begin
            starve_nxt_s = 4'd0;
        end else if (grant_dma_s) begin
            starve_nxt_s = 4'd0;
        end else if (starve_r >= STARVE_MAX) begin
            starve_nxt_s = STARVE_MAX;
        end else begin
            starve_nxt_s = starve_r + 4'd1;
        end
    end

    // Access sequencer with registered BRAM strobes, acks and read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            starve_r    <= 4'd0;
            we_r        <= 1'b0;
            owner_r     <= 1'b0;
            busy_r      <= 1'b0;
            clka_r      <= 1'b0;
            wea_r       <= 1'b0;
            addra_r     <= '0;
            dia_r       <= '0;
            cpu_ack_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
            cpu_rdata_r <= '0;
            dma_rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_ack_r <= 1'b0;
                    dma_ack_r <= 1'b0;
                    clka_r    <= 1'b0;
                    starve_r  <= starve_nxt_s;
                    if (any_req_s) begin
                        state_r <= ST_SETUP;
                        owner_r <= grant_dma_s;
                        we_r    <= sel_we_s;
                        wea_r   <= sel_we_s;
                        addra_r <= sel_addr_s;
                        dia_r   <= sel_wdata_s;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    clka_r  <= 1'b1;
                    state_r <= ST_STROBE;
                end
                ST_STROBE: begin
                    clka_r  <= 1'b0;
                    wea_r   <= 1'b0;
                    state_r <= ST_CAPTURE;
                    if (owner_r) begin
                        dma_ack_r <= 1'b1;
                    end else begin
                        cpu_ack_r <= 1'b1;
                    end
                    // Only reads update the owner's read-data register.
                    if (!we_r) begin
                        if (owner_r) begin
                            dma_rdata_r <= i_ram_doa;
                        end else begin
                            cpu_rdata_r <= i_ram_doa;
                        end
                    end
                end
                ST_CAPTURE: begin
                    cpu_ack_r <= 1'b0;
                    dma_ack_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clka_r    <= 1'b0;
                    wea_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    cpu_ack_r <= 1'b0;
                    dma_ack_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_cpu_ack   = cpu_ack_r;
    assign o_cpu_rdata = cpu_rdata_r;
    assign o_dma_ack   = dma_ack_r;
    assign o_dma_rdata = dma_rdata_r;
    assign o_ram_clka  = clka_r;
    assign o_ram_wea   = wea_r;
    assign o_ram_addra = addra_r;
    assign o_ram_dia   = dia_r;
    assign o_busy      = busy_r;
    assign o_owner     = owner_r;

endmodule
